// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register file's single write port
// between the in-order pipeline (requester 0) and the multi-cycle unit
// (requester 1). Requester 0 has fixed priority. Requester 1 is forced
// through after maxWait consecutive denied cycles. A pending-write scoreboard
// tracks the destinations of issued multi-cycle ops so that readers can
// detect hazards.
module wb_port_arbiter #(
    parameter int width     = 32,
    parameter int addrWidth = 5,
    parameter int maxWait   = 4
) (
    input  logic                 clock,
    input  logic                 clear,

    input  logic                 req0Valid,
    output logic                 req0Ready,
    input  logic [addrWidth-1:0] req0Addr,
    input  logic [width-1:0]     req0Data,

    input  logic                 req1Valid,
    output logic                 req1Ready,
    input  logic [addrWidth-1:0] req1Addr,
    input  logic [width-1:0]     req1Data,

    input  logic                 issue1Valid,
    input  logic [addrWidth-1:0] issue1Addr,

    input  logic [addrWidth-1:0] chkAddrA,
    input  logic [addrWidth-1:0] chkAddrB,
    output logic                 hazardA,
    output logic                 hazardB,

    output logic                 regWriteEnable,
    output logic [addrWidth-1:0] addrD,
    output logic [width-1:0]     dataD,
    output logic                 grantOwner,
    output logic                 errOverlap
);

    localparam int NumRegs = 2 ** addrWidth;
    // maxWait is limited to 1..15, so four bits always hold the count.
    localparam int WaitW   = 4;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(maxWait);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WaitW-1:0]     waitCnt_q,    waitCnt_d;
    logic [NumRegs-1:0]   pending_q,    pending_d;
    logic                 wen_q,        wen_d;
    logic [addrWidth-1:0] addr_q,       addr_d;
    logic [width-1:0]     data_q,       data_d;
    logic                 owner_q,      owner_d;
    logic                 errOverlap_q, errOverlap_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic starve;   // requester 1 has waited long enough to be forced through
    logic xfer0;    // requester 0 transfers at the coming edge
    logic xfer1;    // requester 1 transfers at the coming edge

    // Fixed priority to requester 0 unless requester 1 has hit the wait limit.
    always_comb begin
        starve    = (waitCnt_q == WaitMax);
        req0Ready = req0Valid && (!req1Valid || !starve);
        req1Ready = req1Valid && (!req0Valid ||  starve);
        xfer0     = req0Valid && req0Ready;
        xfer1     = req1Valid && req1Ready;
    end

    // Count consecutive denied cycles of requester 1, saturating at the limit.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (!req1Valid || req1Ready) begin
            waitCnt_d = '0;
        end else if (waitCnt_q != WaitMax) begin
            waitCnt_d = waitCnt_q + WaitW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output stage: one-cycle latency to the register file write port.
    // Writes to register 0 are accepted but never enable the write.
    // ------------------------------------------------------------------

    // Select the accepted transfer (at most one) into the output registers.
    always_comb begin
        wen_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        owner_d = owner_q;
        if (xfer0) begin
            wen_d   = (req0Addr != '0);
            addr_d  = req0Addr;
            data_d  = req0Data;
            owner_d = 1'b0;
        end else if (xfer1) begin
            wen_d   = (req1Addr != '0);
            addr_d  = req1Addr;
            data_d  = req1Data;
            owner_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: one pending bit per register. An issue sets the bit,
    // a requester 1 writeback to the same register clears it; when both
    // happen together the new op is outstanding, so set wins. Register 0
    // is hardwired and never pending.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NumRegs; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_bit
                logic set_bit;
                logic clr_bit;
                assign set_bit = issue1Valid && (issue1Addr == addrWidth'(gi));
                assign clr_bit = xfer1 && (req1Addr == addrWidth'(gi));
                assign pending_d[gi] = set_bit || (pending_q[gi] && !clr_bit);
            end
        end
    endgenerate

    logic issue_hits_pending;   // issue targets a register already outstanding
    logic issue_is_cleared;     // ... whose writeback completes this same cycle

    // Flag a second issue to a register whose earlier op has not written back.
    always_comb begin
        issue_hits_pending = issue1Valid && (issue1Addr != '0) && pending_q[issue1Addr];
        issue_is_cleared   = xfer1 && (req1Addr == issue1Addr);
        errOverlap_d       = errOverlap_q || (issue_hits_pending && !issue_is_cleared);
    end

    // Hazards reflect the scoreboard as it stood before the coming edge.
    always_comb begin
        hazardA = pending_q[chkAddrA] && (chkAddrA != '0);
        hazardB = pending_q[chkAddrB] && (chkAddrB != '0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // All state clears immediately when clear goes low and holds while low.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            waitCnt_q    <= '0;
            pending_q    <= '0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            owner_q      <= 1'b0;
            errOverlap_q <= 1'b0;
        end else begin
            waitCnt_q    <= waitCnt_d;
            pending_q    <= pending_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            owner_q      <= owner_d;
            errOverlap_q <= errOverlap_d;
        end
    end

    assign regWriteEnable = wen_q;
    assign addrD          = addr_q;
    assign dataD          = data_q;
    assign grantOwner     = owner_q;
    assign errOverlap     = errOverlap_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a behavioural model of the
// arbitration, output stage and scoreboard is compared against the DUT on
// every negedge, and directed phases add hand-computed literal checks.
module tb_wb_port_arbiter;

    localparam int W    = 32;
    localparam int AW   = 5;
    localparam int MAXW = 4;
    localparam int NR   = 2 ** AW;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          req0Valid = 1'b0;
    logic          req0Ready;
    logic [AW-1:0] req0Addr = '0;
    logic [W-1:0]  req0Data = '0;
    logic          req1Valid = 1'b0;
    logic          req1Ready;
    logic [AW-1:0] req1Addr = '0;
    logic [W-1:0]  req1Data = '0;
    logic          issue1Valid = 1'b0;
    logic [AW-1:0] issue1Addr = '0;
    logic [AW-1:0] chkAddrA = '0;
    logic [AW-1:0] chkAddrB = '0;
    logic          hazardA;
    logic          hazardB;
    logic          regWriteEnable;
    logic [AW-1:0] addrD;
    logic [W-1:0]  dataD;
    logic          grantOwner;
    logic          errOverlap;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.width(W), .addrWidth(AW), .maxWait(MAXW)) dut (
        .clock          (clock),
        .clear          (clear),
        .req0Valid      (req0Valid),
        .req0Ready      (req0Ready),
        .req0Addr       (req0Addr),
        .req0Data       (req0Data),
        .req1Valid      (req1Valid),
        .req1Ready      (req1Ready),
        .req1Addr       (req1Addr),
        .req1Data       (req1Data),
        .issue1Valid    (issue1Valid),
        .issue1Addr     (issue1Addr),
        .chkAddrA       (chkAddrA),
        .chkAddrB       (chkAddrB),
        .hazardA        (hazardA),
        .hazardB        (hazardB),
        .regWriteEnable (regWriteEnable),
        .addrD          (addrD),
        .dataD          (dataD),
        .grantOwner     (grantOwner),
        .errOverlap     (errOverlap)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int           m_wait;          // consecutive cycles requester 1 was denied
    bit           m_pend [NR];     // registers with an outstanding multi-cycle write
    bit           m_we;
    int           m_addr;
    logic [W-1:0] m_data;
    bit           m_owner;
    bit           m_err;

    function automatic bit m_r0(input bit v0, input bit v1, input int wt);
        return v0 && (!v1 || wt < MAXW);
    endfunction

    function automatic bit m_r1(input bit v0, input bit v1, input int wt);
        return v1 && (!v0 || wt == MAXW);
    endfunction

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_wait = 0; m_we = 0; m_addr = 0; m_data = '0; m_owner = 0; m_err = 0;
            for (int i = 0; i < NR; i++) m_pend[i] = 0;
        end else begin
            bit r0, r1;
            bit snap [NR];
            r0 = m_r0(req0Valid, req1Valid, m_wait);
            r1 = m_r1(req0Valid, req1Valid, m_wait);
            for (int i = 0; i < NR; i++) snap[i] = m_pend[i];
            m_we = 0;
            if (r0) begin
                m_we = (req0Addr != 0); m_addr = req0Addr; m_data = req0Data; m_owner = 0;
                $display("xfer owner=0 addr=%0d data=%08h", req0Addr, req0Data);
            end else if (r1) begin
                m_we = (req1Addr != 0); m_addr = req1Addr; m_data = req1Data; m_owner = 1;
                $display("xfer owner=1 addr=%0d data=%08h", req1Addr, req1Data);
            end
            if (!req1Valid || r1) m_wait = 0;
            else if (m_wait < MAXW) m_wait = m_wait + 1;
            if (r1) m_pend[req1Addr] = 0;
            if (issue1Valid && issue1Addr != 0) begin
                if (snap[issue1Addr] && !(r1 && req1Addr == issue1Addr)) m_err = 1;
                m_pend[issue1Addr] = 1;
            end
        end
    end

    // Every cycle outside reset, compare all outputs with the model.
    always @(negedge clock) begin
        if (clear) begin
            check("req0Ready", req0Ready, m_r0(req0Valid, req1Valid, m_wait));
            check("req1Ready", req1Ready, m_r1(req0Valid, req1Valid, m_wait));
            check("hazardA", hazardA, m_pend[chkAddrA] && chkAddrA != 0);
            check("hazardB", hazardB, m_pend[chkAddrB] && chkAddrB != 0);
            check("regWriteEnable", regWriteEnable, m_we);
            check("addrD", addrD, m_addr);
            check("dataD", dataD, m_data);
            check("grantOwner", grantOwner, m_owner);
            check("errOverlap", errOverlap, m_err);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0Valid = 0; req1Valid = 0; issue1Valid = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_we"},    regWriteEnable, 0);
        check({tag, "_addr"},  addrD, 0);
        check({tag, "_data"},  dataD, 0);
        check({tag, "_owner"}, grantOwner, 0);
        check({tag, "_err"},   errOverlap, 0);
        check({tag, "_hazA"},  hazardA, 0);
    endtask

    initial begin
        logic [9:0] pat;
        repeat (3) step();
        clear = 1;
        step();
        check_cleared("idle_after_reset");

        // Asynchronous reset mid-cycle with pending[3] and a write in flight.
        chkAddrA = 3;
        issue1Valid = 1; issue1Addr = 3;
        req0Valid = 1; req0Addr = 4; req0Data = 32'h000000A5;
        step();
        idle();
        check("pre_reset_we", regWriteEnable, 1);
        check("pre_reset_hazA", hazardA, 1);
        #1 clear = 0;
        #1 check_cleared("async_reset");
        step();
        check_cleared("reset_held");
        clear = 1;
        step();
        step();
        check_cleared("after_release");

        // Single pipeline write.
        req0Valid = 1; req0Addr = 5; req0Data = 32'hDEADBEEF;
        #1 check("single_ready", req0Ready, 1);
        step();
        idle();
        check("single_we", regWriteEnable, 1);
        check("single_addr", addrD, 5);
        check("single_data", dataD, 32'hDEADBEEF);
        check("single_owner", grantOwner, 0);
        step();
        check("single_we_drop", regWriteEnable, 0);

        // Contention: requester 1 forced through on cycles 5 and 10.
        pat = 10'b10_0001_0000;
        req0Valid = 1; req0Addr = 1; req0Data = 32'h11111111;
        req1Valid = 1; req1Addr = 2; req1Data = 32'h22222222;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("cont_r1_c%0d", i + 1), req1Ready, pat[i]);
            check($sformatf("cont_r0_c%0d", i + 1), req0Ready, !pat[i]);
            step();
        end
        idle();
        check("cont_owner", grantOwner, 1);
        check("cont_addr", addrD, 2);
        step();

        // Register 0 write from requester 1.
        req1Valid = 1; req1Addr = 0; req1Data = 32'h12345678;
        #1 check("r0_ready", req1Ready, 1);
        step();
        idle();
        check("r0_we", regWriteEnable, 0);
        check("r0_owner", grantOwner, 1);
        check("r0_data", dataD, 32'h12345678);

        // Scoreboard set / clear / simultaneous set-and-clear.
        chkAddrB = 7;
        issue1Valid = 1; issue1Addr = 7;
        #1 check("sb_before", hazardB, 0);
        step();
        idle();
        check("sb_set", hazardB, 1);
        req1Valid = 1; req1Addr = 7; req1Data = 32'h77;
        step();
        idle();
        check("sb_clr", hazardB, 0);
        issue1Valid = 1; issue1Addr = 7;
        step();
        idle();
        check("sb_set2", hazardB, 1);
        req1Valid = 1; req1Addr = 7; req1Data = 32'h78;
        issue1Valid = 1; issue1Addr = 7;
        step();
        idle();
        check("sb_setwins", hazardB, 1);
        check("sb_noerr", errOverlap, 0);
        req1Valid = 1; req1Addr = 7; req1Data = 32'h79;
        step();
        idle();
        check("sb_clr2", hazardB, 0);

        // Overlap error: sticky until clear.
        issue1Valid = 1; issue1Addr = 9;
        step();
        step();
        idle();
        check("ovl_set", errOverlap, 1);
        repeat (10) step();
        check("ovl_sticky", errOverlap, 1);
        #1 clear = 0;
        #1 check("ovl_clear", errOverlap, 0);
        step();
        clear = 1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
